// File: rtl/squash_pkg.sv
// Shared encodings and parameter defaults for the squash reset sequencer.
package squash_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_READY   = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_t;

  localparam int DEB_CYCLES_DEF     = 16;
  localparam int STRETCH_CYCLES_DEF = 64;
  localparam int SYNC_STAGES_DEF    = 2;

endpackage

// File: rtl/squash_debounce.sv
// Synchroniser plus debouncer for one asynchronous active-low input.
// Latency SYNC_STAGES + DEB_CYCLES edges from a stable change to level; no flow control.
module squash_debounce
  import squash_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [15:0]            cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= 16'd0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      // Any sample agreeing with the accepted level restarts the count.
      if (synced == level) begin
        cnt <= 16'd0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/squash_reset_seq.sv
// Reset sequencer for the squash core: debounces buttons, stretches reset, pulses gpio_ready.
// Outputs are registered decodes of the next state; no flow control.
module squash_reset_seq
  import squash_pkg::*;
#(
  parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ext_reset_n,
  input  logic       pause_n_in,
  input  logic       new_game_n_in,
  output logic       design_reset,
  output logic       gpio_ready,
  output logic       pause_n,
  output logic       new_game_n,
  output logic [1:0] seq_state
);

  localparam logic [15:0] STRETCH_LAST = 16'(STRETCH_CYCLES - 1);

  seq_state_t  state;
  seq_state_t  state_nx;
  logic [15:0] stretch_cnt;
  logic        ext_deb;
  logic        pause_deb;
  logic        new_game_deb;

  squash_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_ext (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ext_reset_n),
    .level   (ext_deb)
  );

  squash_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_pause (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (pause_n_in),
    .level   (pause_deb)
  );

  squash_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_new_game (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (new_game_n_in),
    .level   (new_game_deb)
  );

  // A falling external reset is checked first so it beats the stretch terminal count.
  always_comb begin
    state_nx = state;
    case (state)
      ST_HOLD:    if (ext_deb) state_nx = ST_STRETCH;
      ST_STRETCH: begin
        if (!ext_deb)                         state_nx = ST_HOLD;
        else if (stretch_cnt == STRETCH_LAST) state_nx = ST_READY;
      end
      ST_READY:   state_nx = ext_deb ? ST_RUN : ST_HOLD;
      ST_RUN:     if (!ext_deb) state_nx = ST_HOLD;
      default:    state_nx = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_HOLD;
      stretch_cnt  <= 16'd0;
      design_reset <= 1'b1;
      gpio_ready   <= 1'b0;
    end else begin
      state        <= state_nx;
      design_reset <= (state_nx == ST_HOLD) || (state_nx == ST_STRETCH);
      gpio_ready   <= (state_nx == ST_READY);
      // Counter holds at its terminal value outside STRETCH until the next HOLD.
      if (state_nx == ST_HOLD) begin
        stretch_cnt <= 16'd0;
      end else if (state == ST_STRETCH && stretch_cnt != STRETCH_LAST) begin
        stretch_cnt <= stretch_cnt + 16'd1;
      end
    end
  end

  assign seq_state  = state;
  assign pause_n    = pause_deb | design_reset;
  assign new_game_n = new_game_deb | design_reset;

endmodule
